// File: rtl/mem_resp_unit.sv
// Multi-cycle data-memory responder behind the MEM-stage port.
// One request at a time; stall holds the pipeline until the single-cycle response.
module mem_resp_unit #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned IDX_W   = 10,
  parameter int unsigned LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              stall,
  output logic              busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam int unsigned Depth       = 2 ** IDX_W;
  localparam logic [3:0]  CntInit     = 4'(LATENCY - 1);
  localparam bit          SingleCycle = (LATENCY == 1);

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              wr_q;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] data_out_q, data_out_d;

  logic [DATA_W-1:0] mem [Depth];

  logic              accept;
  logic              commit;
  logic              cm_wr;
  logic [IDX_W-1:0]  cm_idx;
  logic [DATA_W-1:0] cm_wdata;

  // addr[0] and bits above the word index never select anything.
  logic unused_addr;
  assign unused_addr = ^{addr[ADDR_W-1:IDX_W+1], addr[0]};

  assign accept = (state_q == IDLE) && enable;

  // The commit edge is the one entering RESP; with single-cycle latency it is
  // also the accept edge, so the live request is used instead of the latches.
  assign commit = SingleCycle ? accept : ((state_q == WAIT) && (cnt_q == 4'd1));

  assign cm_wr    = SingleCycle ? wr               : wr_q;
  assign cm_idx   = SingleCycle ? addr[IDX_W:1]    : idx_q;
  assign cm_wdata = SingleCycle ? data_in          : wdata_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (enable) begin
          if (SingleCycle) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CntInit;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Outside the commit edge the output register clears, so data_out is zero
  // everywhere except the RESP cycle of a read.
  always_comb begin
    data_out_d = '0;
    if (commit && !cm_wr) begin
      data_out_d = mem[cm_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      wr_q       <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      data_out_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      data_out_q <= data_out_d;
      if (accept) begin
        wr_q    <= wr;
        idx_q   <= addr[IDX_W:1];
        wdata_q <= data_in;
      end
    end
  end

  // Array has no reset; rst only suppresses a pending commit.
  always_ff @(posedge clk) begin
    if (!rst && commit && cm_wr) begin
      mem[cm_idx] <= cm_wdata;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = (state_q == RESP);
  assign busy       = (state_q != IDLE);
  assign stall      = accept || (state_q == WAIT);

endmodule

// File: tb/tb_mem_resp_unit.sv
// Scoreboard bench for mem_resp_unit: a LATENCY=4 and a LATENCY=1 instance,
// checked against an array-level memory model with exact response cycles.
module tb_mem_resp_unit;

  typedef struct {
    logic [15:0] data;
    int          cyc;
  } resp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        en_a = 1'b0, wr_a = 1'b0;
  logic [15:0] addr_a = '0, din_a = '0, dout_a;
  logic        dv_a, stall_a, busy_a;

  logic        en_b = 1'b0, wr_b = 1'b0;
  logic [15:0] addr_b = '0, din_b = '0, dout_b;
  logic        dv_b, stall_b, busy_b;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  resp_t exp_a[$];
  resp_t exp_b[$];

  logic [15:0] model_a [1024];
  logic [15:0] model_b [1024];
  int          known_a[$];
  int          known_b[$];

  mem_resp_unit #(.DATA_W(16), .ADDR_W(16), .IDX_W(10), .LATENCY(4)) dut_a (
    .clk(clk), .rst(rst), .enable(en_a), .wr(wr_a), .addr(addr_a), .data_in(din_a),
    .data_out(dout_a), .data_valid(dv_a), .stall(stall_a), .busy(busy_a)
  );

  mem_resp_unit #(.DATA_W(16), .ADDR_W(16), .IDX_W(10), .LATENCY(1)) dut_b (
    .clk(clk), .rst(rst), .enable(en_b), .wr(wr_b), .addr(addr_b), .data_in(din_b),
    .data_out(dout_b), .data_valid(dv_b), .stall(stall_b), .busy(busy_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
  endtask

  function automatic int widx(input logic [15:0] a);
    return (int'(a) / 2) % 1024;
  endfunction

  // Response monitors: pop on every completion pulse, data_out must be 0 otherwise.
  always @(negedge clk) begin
    resp_t e;
    if (!rst) begin
      if (dv_a) begin
        if (exp_a.size() == 0) check("a_unexpected_valid", 1, 0);
        else begin
          e = exp_a.pop_front();
          check("a_data", dout_a, e.data);
          check("a_resp_cycle", cyc, e.cyc);
        end
      end else check("a_data_zero", dout_a, 0);
    end
  end

  always @(negedge clk) begin
    resp_t e;
    if (!rst) begin
      if (dv_b) begin
        if (exp_b.size() == 0) check("b_unexpected_valid", 1, 0);
        else begin
          e = exp_b.pop_front();
          check("b_data", dout_b, e.data);
          check("b_resp_cycle", cyc, e.cyc);
        end
      end else check("b_data_zero", dout_b, 0);
    end
  end

  // Issues a request on A in the current cycle (c0) and walks it through c4.
  // glitch: in c2 the pipeline changes addr/wr/data, which must be ignored.
  task automatic req_a(input bit w, input logic [15:0] a, input logic [15:0] d,
                       input bit glitch);
    resp_t e;
    int    i;
    i = widx(a);
    en_a = 1'b1; wr_a = w; addr_a = a; din_a = d;
    e.data = w ? 16'h0000 : model_a[i];
    e.cyc  = cyc + 4;
    exp_a.push_back(e);
    if (w) begin
      model_a[i] = d;
      known_a.push_back(i);
    end
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      check("a_stall", stall_a, (k < 4) ? 1 : 0);
      check("a_busy", busy_a, (k > 0) ? 1 : 0);
      @(posedge clk); #1;
      if (glitch && k == 1) begin
        addr_a = 16'h0020; wr_a = 1'b1; din_a = 16'hDEAD;
      end
    end
    en_a = 1'b0;
  endtask

  // Write on A with rst raised in cycle c_k; k=3 hits the commit edge itself.
  task automatic abort_a(input logic [15:0] a, input logic [15:0] d, input int k);
    en_a = 1'b1; wr_a = 1'b1; addr_a = a; din_a = d;
    repeat (k) @(posedge clk);
    #1;
    rst = 1'b1; en_a = 1'b0;
    @(negedge clk);
    check("abort_stall_before", stall_a, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_busy", busy_a, 0);
    check("abort_stall", stall_a, 0);
    check("abort_valid", dv_a, 0);
    @(posedge clk); #1;
  endtask

  task automatic idle_a(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check("a_idle_busy", busy_a, 0);
      check("a_idle_stall", stall_a, 0);
      @(posedge clk); #1;
    end
  endtask

  // Request on B (LATENCY=1); enable stays high through RESP like a stalled pipeline.
  task automatic req_b(input bit w, input logic [15:0] a, input logic [15:0] d);
    resp_t e;
    int    i;
    i = widx(a);
    en_b = 1'b1; wr_b = w; addr_b = a; din_b = d;
    e.data = w ? 16'h0000 : model_b[i];
    e.cyc  = cyc + 1;
    exp_b.push_back(e);
    if (w) begin
      model_b[i] = d;
      known_b.push_back(i);
    end
    @(negedge clk);
    check("b_stall_c0", stall_b, 1);
    check("b_busy_c0", busy_b, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("b_stall_c1", stall_b, 0);
    check("b_busy_c1", busy_b, 1);
    @(posedge clk); #1;
  endtask

  function automatic logic [15:0] alias_addr(input int i);
    logic [15:0] a;
    a        = 16'($urandom);
    a[10:1]  = 10'(i);
    return a;
  endfunction

  initial begin
    logic [15:0] a, d;
    int          i;

    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_busy_a", busy_a, 0);
    check("rst_valid_a", dv_a, 0);
    check("rst_dout_a", dout_a, 0);
    check("rst_stall_a", stall_a, 0);
    check("rst_busy_b", busy_b, 0);
    check("rst_stall_b", stall_b, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle_a(1);

    // Directed cases.
    req_a(1'b1, 16'h0010, 16'hBEEF, 1'b0);
    idle_a(1);
    req_a(1'b0, 16'h0010, 16'h0000, 1'b0);
    req_a(1'b0, 16'h0010, 16'h0000, 1'b1);
    req_a(1'b0, 16'h0020, 16'h0000, 1'b0);
    abort_a(16'h0010, 16'h1234, 2);
    req_a(1'b0, 16'h0010, 16'h0000, 1'b0);
    req_a(1'b1, 16'h0811, 16'hA5A5, 1'b0);
    req_a(1'b0, 16'h0010, 16'h0000, 1'b0);
    abort_a(16'h0010, 16'h7777, 3);
    req_a(1'b0, 16'h0011, 16'h0000, 1'b0);
    // Model now knows index 16 (0x0020) was never written; seed it.
    req_a(1'b1, 16'h0020, 16'h0F0F, 1'b0);

    // Randomized traffic on A.
    for (int n = 0; n < 30; n++) begin
      idle_a($urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1) begin
        a = 16'($urandom); d = 16'($urandom);
        req_a(1'b1, a, d, 1'($urandom_range(0, 1)));
      end else begin
        i = known_a[$urandom_range(0, known_a.size() - 1)];
        req_a(1'b0, alias_addr(i), 16'h0000, 1'($urandom_range(0, 1)));
      end
    end
    idle_a(2);

    // LATENCY=1: enable held high, back-to-back accepts every second cycle.
    req_b(1'b1, 16'h0010, 16'hC0DE);
    req_b(1'b0, 16'h0010, 16'h0000);
    for (int n = 0; n < 20; n++) begin
      if ($urandom_range(0, 1) == 1) begin
        a = 16'($urandom); d = 16'($urandom);
        req_b(1'b1, a, d);
      end else begin
        i = known_b[$urandom_range(0, known_b.size() - 1)];
        req_b(1'b0, alias_addr(i), 16'h0000);
      end
    end
    en_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("b_end_busy", busy_b, 0);
    check("a_queue_empty", exp_a.size(), 0);
    check("b_queue_empty", exp_b.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
